// File: rtl/forward_scoreboard.sv
// EX-stage operand forwarding with a load scoreboard: resolves RS1/RS2 from
// producer stages or returning load data, and stalls on load-use, WAW and full-queue hazards.
module forward_scoreboard #(
  parameter int XLEN        = 32,
  parameter int XADDR       = 5,
  parameter int NUM_STAGES  = 2,
  parameter int MAX_PENDING = 2,
  parameter int CNT_W       = 32,
  localparam int PW         = $clog2(MAX_PENDING + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [XLEN-1:0]             i_rs1_ex,
  input  logic [XLEN-1:0]             i_rs2_ex,
  input  logic [XADDR-1:0]            i_rs1_addr_ex,
  input  logic [XADDR-1:0]            i_rs2_addr_ex,
  input  logic                        i_rs1_used_ex,
  input  logic                        i_rs2_used_ex,
  input  logic [NUM_STAGES*XLEN-1:0]  i_rd_fwd,
  input  logic [NUM_STAGES*XADDR-1:0] i_rd_addr_fwd,
  input  logic [NUM_STAGES-1:0]       i_rd_fwd_wr_en,
  input  logic [NUM_STAGES-1:0]       i_rd_fwd_ready,
  input  logic                        i_ld_issue,
  input  logic [XADDR-1:0]            i_ld_rd_addr,
  input  logic                        i_ld_done,
  input  logic [XADDR-1:0]            i_ld_done_addr,
  input  logic [XLEN-1:0]             i_ld_done_data,
  output logic [XLEN-1:0]             or_rs1,
  output logic [XLEN-1:0]             or_rs2,
  output logic                        o_stall_ex,
  output logic [PW-1:0]               o_pending_cnt,
  output logic                        o_sb_err,
  output logic [CNT_W-1:0]            o_stall_cycles
);

  localparam int NREG = 1 << XADDR;

  typedef struct packed {
    logic            haz;
    logic [XLEN-1:0] val;
  } res_t;

  logic [NREG-1:0]  pending_q, pending_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic             sb_err_q;
  logic [CNT_W-1:0] stall_cycles_q;

  res_t rs1_res, rs2_res;
  logic waw_stall, cap_stall, stall;
  logic issue_acc, done_valid;

  // Youngest matching writer wins; a match on a not-yet-ready stage shadows older sources.
  function automatic res_t resolve(
    input logic [XADDR-1:0]            addr,
    input logic [XLEN-1:0]             rf_val,
    input logic [NUM_STAGES*XLEN-1:0]  fwd,
    input logic [NUM_STAGES*XADDR-1:0] fwd_addr,
    input logic [NUM_STAGES-1:0]       wr_en,
    input logic [NUM_STAGES-1:0]       ready,
    input logic                        done,
    input logic [XADDR-1:0]            done_addr,
    input logic [XLEN-1:0]             done_data,
    input logic [NREG-1:0]             pend
  );
    res_t r;
    logic found;
    r.haz = 1'b0;
    r.val = rf_val;
    found = 1'b0;
    if (addr != '0) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (!found && wr_en[k] && (fwd_addr[k*XADDR +: XADDR] == addr)) begin
          found = 1'b1;
          if (ready[k]) r.val = fwd[k*XLEN +: XLEN];
          else          r.haz = 1'b1;
        end
      end
      if (!found) begin
        if (done && (done_addr == addr)) r.val = done_data;
        else if (pend[addr])             r.haz = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    rs1_res = resolve(i_rs1_addr_ex, i_rs1_ex, i_rd_fwd, i_rd_addr_fwd, i_rd_fwd_wr_en,
                      i_rd_fwd_ready, i_ld_done, i_ld_done_addr, i_ld_done_data, pending_q);
    rs2_res = resolve(i_rs2_addr_ex, i_rs2_ex, i_rd_fwd, i_rd_addr_fwd, i_rd_fwd_wr_en,
                      i_rd_fwd_ready, i_ld_done, i_ld_done_addr, i_ld_done_data, pending_q);
  end

  assign waw_stall = i_ld_issue && (i_ld_rd_addr != '0) && pending_q[i_ld_rd_addr]
                     && !(i_ld_done && (i_ld_done_addr == i_ld_rd_addr));
  assign cap_stall = i_ld_issue && (cnt_q == PW'(MAX_PENDING)) && !i_ld_done;
  assign stall     = (rs1_res.haz && i_rs1_used_ex) || (rs2_res.haz && i_rs2_used_ex)
                     || waw_stall || cap_stall;

  assign issue_acc  = i_ld_issue && !stall && (i_ld_rd_addr != '0);
  assign done_valid = i_ld_done && pending_q[i_ld_done_addr];

  // Clear before set so a same-cycle reissue of the completing register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (done_valid) pending_d[i_ld_done_addr] = 1'b0;
    if (issue_acc)  pending_d[i_ld_rd_addr]   = 1'b1;
    cnt_d = cnt_q + PW'(issue_acc) - PW'(done_valid);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending_q      <= '0;
      cnt_q          <= '0;
      sb_err_q       <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      sb_err_q  <= i_ld_done && !pending_q[i_ld_done_addr];
      if (stall && !(&stall_cycles_q)) stall_cycles_q <= stall_cycles_q + 1'b1;
    end
  end

  assign or_rs1         = rs1_res.val;
  assign or_rs2         = rs2_res.val;
  assign o_stall_ex     = stall;
  assign o_pending_cnt  = cnt_q;
  assign o_sb_err       = sb_err_q;
  assign o_stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard: forwarding priority, x0, load-use,
// scoreboard lifecycle, capacity/WAW stalls, error pulse and mid-operation reset.
module tb_forward_scoreboard;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_rs1_ex, i_rs2_ex;
  logic [4:0]  i_rs1_addr_ex, i_rs2_addr_ex;
  logic        i_rs1_used_ex, i_rs2_used_ex;
  logic [63:0] i_rd_fwd;
  logic [9:0]  i_rd_addr_fwd;
  logic [1:0]  i_rd_fwd_wr_en, i_rd_fwd_ready;
  logic        i_ld_issue;
  logic [4:0]  i_ld_rd_addr;
  logic        i_ld_done;
  logic [4:0]  i_ld_done_addr;
  logic [31:0] i_ld_done_data;
  logic [31:0] or_rs1, or_rs2;
  logic        o_stall_ex;
  logic [1:0]  o_pending_cnt;
  logic        o_sb_err;
  logic [31:0] o_stall_cycles;

  int checks = 0;
  int errors = 0;

  forward_scoreboard dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rs1_ex(i_rs1_ex), .i_rs2_ex(i_rs2_ex),
    .i_rs1_addr_ex(i_rs1_addr_ex), .i_rs2_addr_ex(i_rs2_addr_ex),
    .i_rs1_used_ex(i_rs1_used_ex), .i_rs2_used_ex(i_rs2_used_ex),
    .i_rd_fwd(i_rd_fwd), .i_rd_addr_fwd(i_rd_addr_fwd),
    .i_rd_fwd_wr_en(i_rd_fwd_wr_en), .i_rd_fwd_ready(i_rd_fwd_ready),
    .i_ld_issue(i_ld_issue), .i_ld_rd_addr(i_ld_rd_addr),
    .i_ld_done(i_ld_done), .i_ld_done_addr(i_ld_done_addr), .i_ld_done_data(i_ld_done_data),
    .or_rs1(or_rs1), .or_rs2(or_rs2), .o_stall_ex(o_stall_ex),
    .o_pending_cnt(o_pending_cnt), .o_sb_err(o_sb_err), .o_stall_cycles(o_stall_cycles)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    i_rst = 1'b1;
    i_rs1_ex = 32'h1111; i_rs2_ex = 32'h2222;
    i_rs1_addr_ex = '0; i_rs2_addr_ex = '0;
    i_rs1_used_ex = 1'b0; i_rs2_used_ex = 1'b0;
    i_rd_fwd = '0; i_rd_addr_fwd = '0; i_rd_fwd_wr_en = '0; i_rd_fwd_ready = '0;
    i_ld_issue = 1'b0; i_ld_rd_addr = '0;
    i_ld_done = 1'b0; i_ld_done_addr = '0; i_ld_done_data = '0;
    tick(); tick();
    chk("rst_cnt", 32'(o_pending_cnt), 0);
    chk("rst_err", 32'(o_sb_err), 0);
    chk("rst_stallcyc", o_stall_cycles, 0);
    i_rst = 1'b0;

    // Forwarding priority: stage0 beats stage1
    i_rs1_addr_ex = 5'd5; i_rs1_used_ex = 1'b1;
    i_rs2_addr_ex = 5'd6; i_rs2_used_ex = 1'b1;
    i_rd_fwd = {32'hBBBB, 32'hAAAA}; i_rd_addr_fwd = {5'd5, 5'd5};
    i_rd_fwd_wr_en = 2'b11; i_rd_fwd_ready = 2'b11;
    #1;
    chk("fwd_rs1_s0", or_rs1, 32'hAAAA);
    chk("fwd_rs2_rf", or_rs2, 32'h2222);
    chk("fwd_nostall", 32'(o_stall_ex), 0);
    i_rd_fwd_wr_en = 2'b10;
    #1;
    chk("fwd_rs1_s1", or_rs1, 32'hBBBB);

    // x0 is never forwarded
    i_rs1_addr_ex = 5'd0; i_rd_addr_fwd = {5'd5, 5'd0};
    i_rd_fwd = {32'hBBBB, 32'h1234}; i_rd_fwd_wr_en = 2'b01;
    #1;
    chk("x0_rs1", or_rs1, 32'h1111);
    chk("x0_nostall", 32'(o_stall_ex), 0);

    // Load-use on not-ready stage0
    i_rs1_addr_ex = 5'd7; i_rd_addr_fwd = {5'd0, 5'd7}; i_rd_fwd_ready = 2'b00;
    #1;
    chk("lu_stall", 32'(o_stall_ex), 1);
    tick();
    chk("lu_stallcyc", o_stall_cycles, 1);
    i_rs1_used_ex = 1'b0;
    #1;
    chk("lu_unused", 32'(o_stall_ex), 0);
    tick();
    chk("lu_stallcyc2", o_stall_cycles, 1);
    i_rd_fwd_wr_en = 2'b00; i_rs1_used_ex = 1'b1; i_rs2_used_ex = 1'b0;

    // Scoreboard lifecycle on x9
    i_rs1_addr_ex = 5'd0;
    i_ld_issue = 1'b1; i_ld_rd_addr = 5'd9;
    tick();
    i_ld_issue = 1'b0;
    chk("sb_cnt1", 32'(o_pending_cnt), 1);
    i_rs1_addr_ex = 5'd9;
    #1;
    chk("sb_pend_stall", 32'(o_stall_ex), 1);
    i_ld_done = 1'b1; i_ld_done_addr = 5'd9; i_ld_done_data = 32'hCAFE;
    #1;
    chk("sb_done_fwd", or_rs1, 32'hCAFE);
    chk("sb_done_nostall", 32'(o_stall_ex), 0);
    tick();
    i_ld_done = 1'b0; i_rs1_addr_ex = 5'd0;
    chk("sb_cnt0", 32'(o_pending_cnt), 0);
    chk("sb_noerr", 32'(o_sb_err), 0);

    // Capacity: x3 and x4 pending, third issue stalls
    i_ld_issue = 1'b1; i_ld_rd_addr = 5'd3; tick();
    i_ld_rd_addr = 5'd4; tick();
    chk("cap_cnt2", 32'(o_pending_cnt), 2);
    i_ld_rd_addr = 5'd5;
    #1;
    chk("cap_stall", 32'(o_stall_ex), 1);
    tick();
    chk("cap_cnt_hold", 32'(o_pending_cnt), 2);
    chk("cap_stallcyc", o_stall_cycles, 2);
    i_ld_done = 1'b1; i_ld_done_addr = 5'd3;
    #1;
    chk("cap_done_ok", 32'(o_stall_ex), 0);
    tick();
    chk("cap_cnt_swap", 32'(o_pending_cnt), 2);
    chk("cap_stallcyc2", o_stall_cycles, 2);

    // WAW on x4 while x5 completes (capacity relieved by the completion)
    i_ld_rd_addr = 5'd4; i_ld_done_addr = 5'd5;
    #1;
    chk("waw_stall", 32'(o_stall_ex), 1);
    tick();
    chk("waw_cnt", 32'(o_pending_cnt), 1);
    chk("waw_stallcyc", o_stall_cycles, 3);

    // Completion to non-pending x10
    i_ld_issue = 1'b0; i_ld_done_addr = 5'd10;
    tick();
    i_ld_done = 1'b0;
    chk("err_pulse", 32'(o_sb_err), 1);
    chk("err_cnt", 32'(o_pending_cnt), 1);
    tick();
    chk("err_clear", 32'(o_sb_err), 0);

    // Issue to x0 leaves scoreboard alone
    i_ld_issue = 1'b1; i_ld_rd_addr = 5'd0;
    tick();
    chk("x0_issue_cnt", 32'(o_pending_cnt), 1);

    // Reset mid-operation
    i_ld_rd_addr = 5'd6;
    tick();
    i_ld_issue = 1'b0;
    chk("pre_rst_cnt", 32'(o_pending_cnt), 2);
    i_rst = 1'b1; i_ld_done = 1'b1; i_ld_done_addr = 5'd6;
    tick();
    i_rst = 1'b0; i_ld_done = 1'b0;
    chk("mrst_cnt", 32'(o_pending_cnt), 0);
    chk("mrst_stallcyc", o_stall_cycles, 0);
    chk("mrst_err", 32'(o_sb_err), 0);
    i_rs1_addr_ex = 5'd4;
    #1;
    chk("mrst_pend_clr", 32'(o_stall_ex), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
